// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and bit-period derivation.
// The transmitter and the receiver both use these.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Integer truncation is accepted; the result must be at least 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_baud_en.sv
// Free-running bit-period divider; bit_tick marks the last clk cycle of each bit.
module uart_baud_en #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bit_tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    assign bit_tick = run && (count == LAST);

    // Held at zero while idle so every frame starts on a fresh bit period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with CTS flow control; frames start only while CTS is
// asserted, and a frame in progress always completes.
module uart_tx import uart_pkg::*; #(
    parameter int BAUD_RATE    = 115200,
    parameter int CLK_FREQ     = 12000000,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic clk,
    input  logic reset_n,
    uart_tx_if.slave bus,
    input  logic cts_n,
    output logic tx,
    output logic busy,
    output logic done
);
    uart_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_cnt, bit_next;
    logic        tx_next, busy_next, done_next;
    logic        cts_meta, cts_sync;
    logic        bit_tick;
    logic        accept;

    uart_baud_en #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (state != IDLE),
        .bit_tick (bit_tick)
    );

    // cts_n comes from the peer's clock domain; reset to the deasserted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign bus.ready_out = (state == IDLE) && !cts_sync;
    assign accept        = bus.valid_in && bus.ready_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_next;
            tx      <= tx_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    // tx is registered, so each value computed here appears on the line one
    // edge later, exactly at the bit boundary.
    always_comb begin
        state_next = state;
        shift_next = shift;
        bit_next   = bit_cnt;
        tx_next    = tx;
        busy_next  = busy;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    shift_next = bus.data_in;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_next    = shift[0];
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        bit_next   = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

8N1 UART transmitter with CTS flow control. It is the transmit counterpart to the team's UART receiver and runs on the same 12 MHz board clock. Bytes are taken from a local valid/ready handshake and serialised LSB-first on `tx`. Bit timing comes from a free-running divider clock-enable, with no derived clock. A new frame starts only while the peer asserts CTS; a frame already in progress always completes.

## Interface
- `BAUD_RATE`, 115200: line rate in bit/s.
- `CLK_FREQ`, 12000000: `clk` frequency in Hz.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD_RATE` (104): clk cycles per bit. Must be ≥ 2; integer truncation is accepted.

- `clk` input 1: system clock; the only clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `data_in` input 8: byte to send; sampled on acceptance only.
- `valid_in` input 1: `data_in` is valid.
- `ready_out` output 1: block can accept a byte this cycle.
- `cts_n` input 1: peer Clear to Send, active-low; asynchronous to `clk`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse at the end of the stop bit.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `done`=0, `ready_out`=0, state IDLE, bit counter 0, divider 0, CTS synchroniser flops =1 (deasserted).
- **CTS synchroniser:** `cts_n` passes through a 2-flop synchroniser; `cts_sync` is the second flop.
- **`ready_out`:** `(state==IDLE) && !cts_sync`, combinational from registers.
- **Acceptance:** a byte is accepted on an edge where `valid_in && ready_out`. At that edge:
  - `data_in` is latched into the shift register;
  - `tx` <= 0;
  - state <= START, divider <= 0, `busy` <= 1.
- **States:**
  - IDLE: `tx`=1.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles. The shift register shifts right at each bit boundary; the bit counter runs 0..7. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then state <= IDLE, `busy` <= 0, `done` <= 1 for one cycle.
- **Divider:** counts 0..`CLKS_PER_BIT`-1 while not IDLE and wraps at the bit boundary. It is held at 0 in IDLE.
- **`valid_in` while not ready:** ignored; `data_in` changes have no effect during a frame.
- **CTS deasserted mid-frame:** the frame completes; the next frame is blocked until `cts_sync`=0.
- **Simultaneous final stop-bit edge and new `valid_in`:** not accepted on that edge. `ready_out` rises the cycle after STOP→IDLE.
- **`reset_n` low mid-frame:** all registers return to reset values immediately. `tx` goes high asynchronously, so a truncated frame is visible to the peer as a framing error.
- No parity, no break generation, and one stop bit only.

## Timing
Take `N = CLKS_PER_BIT`, with the acceptance edge at E0.
- `tx` low from E0 to E0+N.
- Data bit k is driven from E0+(k+1)N for N cycles.
- Stop bit runs from E0+9N.
- `done` is high for the cycle after E0+10N; `busy` is high from E0 to E0+10N.
- `ready_out` is high again after E0+10N, so the earliest next acceptance is E0+10N+1. The back-to-back frame period is therefore 10N+1 cycles (1 cycle of extra idle).
- CTS latency: `cts_n` falling → `ready_out` high in 2–3 clk cycles.
- After `reset_n` deassertion with `cts_n` already low, `ready_out` rises on the 2nd clk edge.

## Structure
- **Shared package `uart_pkg`** holds:
  - state encodings (IDLE, START, DATA, STOP), shared with the receiver's encoding space;
  - the `CLKS_PER_BIT` derivation;
  - the frame-length constant (10 bits).
- **Sub-module `uart_baud_en`** is natural: a parameterised divider with a `run` input that emits a one-cycle `bit_tick` at each wrap, reset async active-low. The top-level FSM, shift register and bit counter stay in `uart_tx`.
- **Target size:** roughly 150–250 lines RTL.

## Test plan
- **Single byte:** `CLK_FREQ`=12000000, `BAUD_RATE`=115200, `cts_n`=0, send 0x55. Required response:
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each 104 cycles;
  - `done` pulses once at E0+1040;
  - a bench UART model decodes 0x55.
- **Back-to-back:** hold `valid_in` high with 0xA5 then 0x3C. Required response:
  - second acceptance at E0+1041;
  - both bytes decoded;
  - exactly 1 extra idle cycle between the stop bit and the next start bit.
- **CTS gating:** `cts_n`=1, `valid_in`=1 with 0x81. Required response:
  - `ready_out`=0 and `tx`=1 indefinitely.
  - Drive `cts_n`=0: acceptance occurs within 3 cycles and 0x81 is sent.
- **CTS drop mid-frame:** raise `cts_n` during data bit 3 of 0xF0. Required response:
  - frame completes correctly;
  - `ready_out` stays 0 afterwards until `cts_n`=0.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 5. Required response:
  - `tx`=1 immediately, without waiting for a clk edge;
  - `busy`=0, `done`=0.
  - After release with `cts_n`=0: `ready_out`=1 on the 2nd edge, and a fresh 0x00 transmits cleanly.
- **Small divider:** `CLKS_PER_BIT`=2, send 0xC3. Required response:
  - every bit is exactly 2 cycles;
  - frame is 20 cycles;
  - `data_in` changes during the frame do not alter the output.
